// File: rtl/btn_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : btn_uart_tx
// Purpose  : Button-triggered 8N1 UART transmitter. Each single-cycle request
//            from the upstream debouncer sends the byte on tx_data. A request
//            that arrives while a frame is in flight is held in a one-deep
//            pending register. A further request while one is already pending
//            is dropped and flagged.
// Ports    : clk_100MHz   in   system clock, rising edge
//            reset_n      in   asynchronous active-low reset
//            btn_tick     in   single-cycle send request
//            tx_data[7:0] in   byte to send, sampled on acceptance
//            tx           out  serial line, idles high (registered)
//            tx_busy      out  high while a frame is in flight (registered)
//            tx_done_tick out  pulse in the final cycle of the last stop bit
//            overrun_tick out  pulse when a request is dropped
// Params   : CLKS_PER_BIT (>= 2) clock cycles per serial bit
//            STOP_BITS    (1|2)  number of stop bits
// Options  : define BTN_UART_TX_PARITY_EN to insert an even-parity bit
//            after the data bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_tick,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       overrun_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

`ifdef BTN_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_stop_cnt;
    logic [7:0]       r_shift;
    logic             r_pending;
    logic [7:0]       r_hold;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;
`ifdef BTN_UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic       w_bit_end;
    logic       w_last_stop;
    logic       w_done_next;
    logic       w_load;
    logic [7:0] w_load_byte;

    assign w_bit_end   = (r_cnt == c_CNT_LAST);
    // With one stop bit the stop counter is never consulted.
    assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
    // Registered done pulse: raise it one cycle early so it lands on the
    // final cycle of the last stop bit.
    assign w_done_next = (r_state == S_STOP) && (r_cnt == c_CNT_PRE) && w_last_stop;
    assign w_load      = (r_state == S_IDLE) && (btn_tick || r_pending);
    assign w_load_byte = r_pending ? r_hold : tx_data;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_shift    <= 8'd0;
            r_pending  <= 1'b0;
            r_hold     <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef BTN_UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done    <= w_done_next;
            r_overrun <= 1'b0;

            // Requests arriving mid-frame, including the done cycle, are queued.
            if ((r_state != S_IDLE) && btn_tick) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                    r_hold    <= tx_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_load) begin
                        r_shift    <= w_load_byte;
`ifdef BTN_UART_TX_PARITY_EN
                        r_parity   <= ^w_load_byte;
`endif
                        // Pending wins the load; a simultaneous new request
                        // takes its place in the holding register.
                        r_pending  <= r_pending & btn_tick;
                        if (r_pending && btn_tick) begin
                            r_hold <= tx_data;
                        end
                        r_cnt      <= '0;
                        r_bit_idx  <= 3'd0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef BTN_UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef BTN_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;
    assign overrun_tick = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_btn_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_btn_uart_tx
// Purpose  : Directed self-checking bench for btn_uart_tx with CLKS_PER_BIT=4.
//            Inputs change and outputs are observed on the falling clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_btn_uart_tx;

    localparam int CPB = 4;
`ifdef BTN_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic       done;
    logic       ovr;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic tx_s   [0:127];
    logic busy_s [0:127];
    logic done_s [0:127];
    logic ovr_s  [0:127];

    btn_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1)
    ) dut (
        .clk_100MHz   (clk),
        .reset_n      (rst_n),
        .btn_tick     (btn),
        .tx_data      (din),
        .tx           (tx),
        .tx_busy      (busy),
        .tx_done_tick (done),
        .overrun_tick (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level at a given cycle offset from the first start-bit cycle.
    function automatic logic exp_bit(input logic [7:0] b, input int off);
        int k;
        k = off / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef BTN_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        btn   = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_hold: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0 || ovr !== 1'b0) begin
            $display("FAIL reset_pulses: done=%b ovr=%b, want 0 0", done, ovr);
        end else pass_cnt++;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL reset_quiet: %0d bad cycles, want 0", bad);
        end else pass_cnt++;
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        int bad;
        int ndone;
        int first_done;
        int nbusy;
        btn = 1'b1;
        din = b;
        @(negedge clk);
        btn = 1'b0;
        for (int c = 0; c < FRAME + 2; c++) begin
            tx_s[c]   = tx;
            busy_s[c] = busy;
            done_s[c] = done;
            @(negedge clk);
        end
        for (int k = 0; k < NBITS; k++) begin
            bad = 0;
            for (int j = 0; j < CPB; j++) begin
                if (tx_s[k*CPB+j] !== exp_bit(b, k*CPB)) bad++;
            end
            total_cnt++;
            if (bad !== 0) begin
                $display("FAIL frame_%02h_bit%0d: %0d wrong cycles, want level %b",
                         b, k, bad, exp_bit(b, k*CPB));
            end else pass_cnt++;
        end
        ndone = 0;
        first_done = -1;
        nbusy = 0;
        for (int c = 0; c < FRAME + 2; c++) begin
            if (done_s[c] === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (busy_s[c] === 1'b1) nbusy++;
        end
        total_cnt++;
        if (ndone !== 1 || first_done !== FRAME - 1) begin
            $display("FAIL frame_%02h_done: count=%0d at=%0d, want count=1 at=%0d",
                     b, ndone, first_done, FRAME - 1);
        end else pass_cnt++;
        total_cnt++;
        if (nbusy !== FRAME) begin
            $display("FAIL frame_%02h_busy: %0d cycles, want %0d", b, nbusy, FRAME);
        end else pass_cnt++;
        total_cnt++;
        if (tx_s[FRAME] !== 1'b1 || busy_s[FRAME] !== 1'b0) begin
            $display("FAIL frame_%02h_after: tx=%b busy=%b, want 1 0",
                     b, tx_s[FRAME], busy_s[FRAME]);
        end else pass_cnt++;
    endtask

    task automatic test_queued_overrun();
        int last;
        int bad;
        int nd;
        int d1;
        int d2;
        int no;
        int o1;
        last = 2 * FRAME + 30;
        btn = 1'b1;
        din = 8'h55;
        @(negedge clk);
        btn = 1'b0;
        for (int c = 0; c < last; c++) begin
            tx_s[c]   = tx;
            busy_s[c] = busy;
            done_s[c] = done;
            ovr_s[c]  = ovr;
            if (c == 10) begin
                btn = 1'b1;
                din = 8'h0F;
            end else if (c == 11) begin
                btn = 1'b0;
                din = 8'hFF;
            end else if (c == 20) begin
                btn = 1'b1;
                din = 8'hAA;
            end else begin
                btn = 1'b0;
            end
            @(negedge clk);
        end
        bad = 0;
        for (int c = 0; c < FRAME; c++) if (tx_s[c] !== exp_bit(8'h55, c)) bad++;
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL queue_first_frame: %0d wrong cycles, want 0", bad);
        end else pass_cnt++;
        total_cnt++;
        if (tx_s[FRAME] !== 1'b1 || busy_s[FRAME] !== 1'b0) begin
            $display("FAIL queue_gap: tx=%b busy=%b, want 1 0", tx_s[FRAME], busy_s[FRAME]);
        end else pass_cnt++;
        bad = 0;
        for (int c = 0; c < FRAME; c++) if (tx_s[FRAME+1+c] !== exp_bit(8'h0F, c)) bad++;
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL queue_second_frame_0F: %0d wrong cycles, want 0", bad);
        end else pass_cnt++;
        nd = 0;
        d1 = -1;
        d2 = -1;
        no = 0;
        o1 = -1;
        for (int c = 0; c < last; c++) begin
            if (done_s[c] === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (ovr_s[c] === 1'b1) begin
                no++;
                if (o1 < 0) o1 = c;
            end
        end
        total_cnt++;
        if (nd !== 2 || d1 !== FRAME - 1 || d2 !== 2 * FRAME) begin
            $display("FAIL queue_done: count=%0d at %0d,%0d, want 2 at %0d,%0d",
                     nd, d1, d2, FRAME - 1, 2 * FRAME);
        end else pass_cnt++;
        total_cnt++;
        if (no !== 1 || o1 !== 21) begin
            $display("FAIL overrun_tick: count=%0d at=%0d, want count=1 at=21", no, o1);
        end else pass_cnt++;
        bad = 0;
        for (int c = 2 * FRAME + 1; c < last; c++) begin
            if (tx_s[c] !== 1'b1 || busy_s[c] !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL overrun_no_third_frame: %0d non-idle cycles, want 0", bad);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        btn = 1'b1;
        din = 8'h34;
        @(negedge clk);
        // Cycle 0 of frame; queue a second request at cycle 6, stop inside bit 3.
        for (int c = 0; c < 17; c++) begin
            btn = (c == 6) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        btn = 1'b0;
        total_cnt++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL midrst_before: tx=%b busy=%b, want 0 1", tx, busy);
        end else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL midrst_immediate: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, done);
        end else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL midrst_pending_cleared: %0d non-idle cycles, want 0", bad);
        end else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        din   = 8'h00;
        test_reset();
        repeat (3) @(negedge clk);
        test_single_frame(8'hA5);
        repeat (3) @(negedge clk);
        test_queued_overrun();
        repeat (3) @(negedge clk);
        test_reset_mid_frame();
`ifdef BTN_UART_TX_PARITY_EN
        repeat (3) @(negedge clk);
        test_single_frame(8'h07);
        repeat (3) @(negedge clk);
        test_single_frame(8'h03);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
